// File: rtl/ntt_row_loader_if.sv
// Stream interface of the NTT row loader: word-wide coefficient input, row-wide output.
// The loader connects through the slave modport; its upstream/downstream driver uses master.
interface ntt_row_loader_if #(
    parameter int DATA_SIZE = 32,
    parameter int PE_NUMBER = 32
);
    logic                           in_valid;
    logic                           in_ready;
    logic [DATA_SIZE-1:0]           in_data;
    logic                           in_last;
    logic                           out_valid;
    logic                           out_ready;
    logic [PE_NUMBER*DATA_SIZE-1:0] out_data;
    logic [3:0]                     out_cycle;
    logic                           out_first;
    logic                           out_last;
    logic                           err_len;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_cycle, out_first, out_last, err_len
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_cycle, out_first, out_last, err_len
    );
endinterface

// File: rtl/ntt_row_loader.sv
// Ping-pong staging buffer: packs coefficients into PE_NUMBER-wide rows and replays
// a full DEPTH-row polynomial with its row index for the bit-reverse stage.
module ntt_row_loader #(
    parameter int DATA_SIZE = 32,
    parameter int PE_NUMBER = 32,
    parameter int DEPTH     = 16
) (
    input logic              clk,
    input logic              reset,
    ntt_row_loader_if.slave  bus
);
    localparam int COL_W = $clog2(PE_NUMBER);
    localparam int ROW_W = $clog2(DEPTH);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(PE_NUMBER - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DEPTH - 1);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

    bank_state_t                    bank_state [2];
    logic [PE_NUMBER*DATA_SIZE-1:0] mem [2][DEPTH];

    logic                           wr_bank;
    logic [COL_W-1:0]               wr_col;
    logic [ROW_W-1:0]               wr_row;
    logic                           rd_bank;
    logic [ROW_W-1:0]               rd_row;
    logic                           out_bank;
    logic                           out_valid;
    logic                           out_last;
    logic                           err_len;

    logic wr_accept;
    logic wr_at_end;
    logic out_fire;
    logic rd_load;

    assign bus.in_ready = (bank_state[wr_bank] == EMPTY) || (bank_state[wr_bank] == FILLING);
    assign wr_accept    = bus.in_valid && bus.in_ready;
    assign wr_at_end    = (wr_col == COL_LAST) && (wr_row == ROW_LAST);
    assign out_fire     = out_valid && bus.out_ready;
    assign rd_load      = ((bank_state[rd_bank] == FULL) || (bank_state[rd_bank] == DRAINING))
                          && (!out_valid || bus.out_ready);

    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_last;
    assign bus.err_len   = err_len;

    // NOTE: coefficient storage has no reset; stale words are never read because a bank
    // is only replayed after it has been completely rewritten.
    always_ff @(posedge clk) begin
        if (wr_accept)
            mem[wr_bank][wr_row][int'(wr_col)*DATA_SIZE +: DATA_SIZE] <= bus.in_data;
    end

    // NOTE: all state here uses non-blocking assignments so every branch sees the
    // pre-edge values, which keeps writer and reader bank updates independent.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_state[0] <= EMPTY;
            bank_state[1] <= EMPTY;
            wr_bank       <= 1'b0;
            wr_col        <= '0;
            wr_row        <= '0;
            rd_bank       <= 1'b0;
            rd_row        <= '0;
            out_bank      <= 1'b0;
            out_valid     <= 1'b0;
            bus.out_data  <= '0;
            bus.out_cycle <= '0;
            bus.out_first <= 1'b0;
            out_last      <= 1'b0;
            err_len       <= 1'b0;
        end else begin
            if (wr_accept) begin
                if (bank_state[wr_bank] == EMPTY)
                    bank_state[wr_bank] <= FILLING;
                // The flag only reports a mismatch; the counters keep their own framing.
                if (bus.in_last != wr_at_end)
                    err_len <= 1'b1;
                if (wr_col == COL_LAST) begin
                    wr_col <= '0;
                    if (wr_row == ROW_LAST) begin
                        wr_row              <= '0;
                        bank_state[wr_bank] <= FULL;
                        wr_bank             <= ~wr_bank;
                    end else begin
                        wr_row <= wr_row + 1'b1;
                    end
                end else begin
                    wr_col <= wr_col + 1'b1;
                end
            end

            // The row sitting in the output register belongs to out_bank, not rd_bank.
            if (out_fire && out_last)
                bank_state[out_bank] <= EMPTY;

            if (rd_load) begin
                if (rd_row == '0)
                    bank_state[rd_bank] <= DRAINING;
                out_valid     <= 1'b1;
                out_bank      <= rd_bank;
                bus.out_data  <= mem[rd_bank][rd_row];
                bus.out_cycle <= rd_row;
                bus.out_first <= (rd_row == '0);
                out_last      <= (rd_row == ROW_LAST);
                if (rd_row == ROW_LAST) begin
                    rd_row  <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    rd_row <= rd_row + 1'b1;
                end
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ntt_row_loader.sv
// Self-checking bench: a stream-level model turns every N accepted words into 16 expected rows.
module tb_ntt_row_loader;
    localparam int DS    = 32;
    localparam int PE    = 32;
    localparam int DEPTH = 16;
    localparam int N     = PE * DEPTH;

    typedef struct {
        logic [DS-1:0] data;
        logic          last;
    } word_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ntt_row_loader_if #(.DATA_SIZE(DS), .PE_NUMBER(PE)) bus ();

    ntt_row_loader #(.DATA_SIZE(DS), .PE_NUMBER(PE), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    word_t          send_q[$];
    logic [DS-1:0]  poly_buf[$];
    logic [PE*DS-1:0] exp_q[$];
    int             exp_row_q[$];
    int             acc_count;
    bit             exp_err;
    int             p_in, p_out;
    int             cyc = 0;
    int             rows_out = 0;
    int             last_acc_cyc, first_valid_cyc, last_row_cyc;
    int             rows_when_ready = -2;

    bit               prev_stall;
    logic [PE*DS-1:0] prev_data;
    logic [3:0]       prev_cycle;
    logic             prev_first, prev_last;

    task automatic clear_model();
        send_q.delete();
        poly_buf.delete();
        exp_q.delete();
        exp_row_q.delete();
        acc_count  = 0;
        exp_err    = 1'b0;
        prev_stall = 1'b0;
    endtask

    // Reference: the accepted stream, cut into polynomials of N words and rows of PE words.
    task automatic model_accept(input word_t w);
        int idx;
        logic [PE*DS-1:0] row;
        idx = acc_count % N;
        if (w.last != (idx == N - 1)) exp_err = 1'b1;
        if (idx == N - 1) last_acc_cyc = cyc;
        poly_buf.push_back(w.data);
        acc_count++;
        if (poly_buf.size() == N) begin
            for (int r = 0; r < DEPTH; r++) begin
                for (int c = 0; c < PE; c++) row[DS*c +: DS] = poly_buf[r*PE + c];
                exp_q.push_back(row);
                exp_row_q.push_back(r);
            end
            poly_buf.delete();
        end
    endtask

    task automatic push_poly(input bit random_data, input int bad_idx);
        word_t w;
        for (int i = 0; i < N; i++) begin
            w.data = random_data ? DS'($urandom) : DS'(i);
            w.last = (i == N - 1) || (i == bad_idx);
            send_q.push_back(w);
        end
    endtask

    // One clock: sample at the falling edge, then drive what the next rising edge will see.
    task automatic cycle();
        logic [PE*DS-1:0] d;
        int r;
        int bad_c;
        @(negedge clk);
        cyc++;
        if (rows_when_ready == -1 && bus.in_ready === 1'b1) rows_when_ready = rows_out;

        tests++;
        if (bus.err_len !== exp_err) begin
            fails++;
            $display("FAIL err_len: got %b want %b at cycle %0d", bus.err_len, exp_err, cyc);
        end

        if (prev_stall) begin
            tests++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data || bus.out_cycle !== prev_cycle ||
                bus.out_first !== prev_first || bus.out_last !== prev_last) begin
                fails++;
                $display("FAIL stall_hold: got valid %b cycle %0d want valid 1 cycle %0d held",
                         bus.out_valid, bus.out_cycle, prev_cycle);
            end
        end

        if (bus.out_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
        bus.out_ready = ($urandom_range(99) < p_out);

        if (bus.out_valid === 1'b1 && bus.out_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL extra_row: got row cycle %0d want no row", bus.out_cycle);
            end else begin
                d = exp_q.pop_front();
                r = exp_row_q.pop_front();
                bad_c = -1;
                for (int c = PE - 1; c >= 0; c--) if (bus.out_data[DS*c +: DS] !== d[DS*c +: DS]) bad_c = c;
                if (bad_c >= 0 || bus.out_cycle !== 4'(r) || bus.out_first !== (r == 0) ||
                    bus.out_last !== (r == DEPTH - 1)) begin
                    fails++;
                    $display("FAIL row %0d: got cycle %0d first %b last %b word[%0d] %h want cycle %0d first %b last %b word %h",
                             r, bus.out_cycle, bus.out_first, bus.out_last, bad_c < 0 ? 0 : bad_c,
                             bus.out_data[DS*(bad_c < 0 ? 0 : bad_c) +: DS], r, r == 0, r == DEPTH - 1,
                             d[DS*(bad_c < 0 ? 0 : bad_c) +: DS]);
                end
                if (r == DEPTH - 1) last_row_cyc = cyc;
            end
            rows_out++;
        end

        prev_stall = (bus.out_valid === 1'b1) && !bus.out_ready;
        prev_data  = bus.out_data;
        prev_cycle = bus.out_cycle;
        prev_first = bus.out_first;
        prev_last  = bus.out_last;

        bus.in_valid = 1'b0;
        if (send_q.size() > 0 && $urandom_range(99) < p_in) begin
            bus.in_valid = 1'b1;
            bus.in_data  = send_q[0].data;
            bus.in_last  = send_q[0].last;
            if (bus.in_ready === 1'b1) model_accept(send_q.pop_front());
        end
    endtask

    task automatic run_idle(input int max_cycles, input string name);
        int n = 0;
        while ((send_q.size() > 0 || exp_q.size() > 0 || bus.out_valid === 1'b1) && n < max_cycles) begin
            cycle();
            n++;
        end
        tests++;
        if (n >= max_cycles) begin
            fails++;
            $display("FAIL %s_timeout: got %0d rows pending %0d words pending want 0", name,
                     exp_q.size(), send_q.size());
        end
    endtask

    task automatic check_reset_values(input string name);
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== '0 ||
            bus.out_cycle !== 4'd0 || bus.out_first !== 1'b0 || bus.out_last !== 1'b0 ||
            bus.err_len !== 1'b0) begin
            fails++;
            $display("FAIL %s: got ready %b valid %b data_nz %b cycle %0d first %b last %b err %b want 1 0 0 0 0 0 0",
                     name, bus.in_ready, bus.out_valid, bus.out_data != '0, bus.out_cycle,
                     bus.out_first, bus.out_last, bus.err_len);
        end
    endtask

    // Reset is asserted and released between clock edges.
    task automatic pulse_reset(input string name);
        #2 reset = 1'b1;
        #1 check_reset_values(name);
        clear_model();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        pulse_reset("reset_async");
        @(negedge clk);
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_single();
        int r0 = rows_out;
        p_in = 100; p_out = 100;
        first_valid_cyc = -1;
        push_poly(1'b0, -1);
        run_idle(2000, "single");
        tests++;
        if (rows_out - r0 != DEPTH) begin
            fails++;
            $display("FAIL single_rows: got %0d want %0d", rows_out - r0, DEPTH);
        end
        tests++;
        if (first_valid_cyc - last_acc_cyc != 2) begin
            fails++;
            $display("FAIL single_latency: got %0d want 2", first_valid_cyc - last_acc_cyc);
        end
        tests++;
        if (last_row_cyc - first_valid_cyc != DEPTH - 1) begin
            fails++;
            $display("FAIL single_throughput: got %0d want %0d", last_row_cyc - first_valid_cyc, DEPTH - 1);
        end
    endtask

    task automatic test_backpressure();
        int r0 = rows_out;
        p_in = 70; p_out = 50;
        push_poly(1'b1, -1);
        push_poly(1'b1, -1);
        run_idle(8000, "backpressure");
        tests++;
        if (rows_out - r0 != 2 * DEPTH) begin
            fails++;
            $display("FAIL backpressure_rows: got %0d want %0d", rows_out - r0, 2 * DEPTH);
        end
    endtask

    task automatic test_back_to_back();
        int a0 = acc_count;
        int r0 = rows_out;
        p_in = 100; p_out = 0;
        push_poly(1'b1, -1);
        push_poly(1'b1, -1);
        push_poly(1'b1, -1);
        for (int i = 0; i < 1100; i++) cycle();
        tests++;
        if (acc_count - a0 != 2 * N || bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL pingpong_full: got %0d words ready %b want %0d words ready 0",
                     acc_count - a0, bus.in_ready, 2 * N);
        end
        rows_when_ready = -1;
        p_out = 100;
        run_idle(4000, "pingpong");
        tests++;
        if (rows_when_ready - r0 != DEPTH) begin
            fails++;
            $display("FAIL pingpong_resume: got %0d rows before ready want %0d", rows_when_ready - r0, DEPTH);
        end
        rows_when_ready = -2;
        tests++;
        if (rows_out - r0 != 3 * DEPTH) begin
            fails++;
            $display("FAIL pingpong_rows: got %0d want %0d", rows_out - r0, 3 * DEPTH);
        end
    endtask

    task automatic test_len_err();
        int r0 = rows_out;
        p_in = 100; p_out = 100;
        push_poly(1'b0, 100);
        run_idle(2000, "len_err");
        tests++;
        if (bus.err_len !== 1'b1 || rows_out - r0 != DEPTH) begin
            fails++;
            $display("FAIL len_err: got err %b rows %0d want err 1 rows %0d", bus.err_len, rows_out - r0, DEPTH);
        end
    endtask

    task automatic test_reset_mid_drain();
        int r0 = rows_out;
        int n = 0;
        p_in = 100; p_out = 100;
        push_poly(1'b1, -1);
        while (rows_out - r0 < 8 && n < 2000) begin
            cycle();
            n++;
        end
        @(posedge clk);
        tests++;
        #2 if (n >= 2000 || bus.out_valid !== 1'b1 || bus.out_cycle !== 4'd8) begin
            fails++;
            $display("FAIL mid_drain_pre: got valid %b cycle %0d want valid 1 cycle 8", bus.out_valid, bus.out_cycle);
        end
        pulse_reset("mid_drain_reset");
        r0 = rows_out;
        push_poly(1'b1, -1);
        run_idle(2000, "mid_drain_fresh");
        tests++;
        if (rows_out - r0 != DEPTH) begin
            fails++;
            $display("FAIL mid_drain_fresh_rows: got %0d want %0d", rows_out - r0, DEPTH);
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        p_in  = 0;
        p_out = 0;
        clear_model();
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;

        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_len_err();
        test_reset_mid_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ntt_row_loader.md
# ntt_row_loader

Input staging buffer directly upstream of the bit-reverse stage. It accepts polynomial coefficients one word at a time over a valid/ready stream and packs them into rows of `PE_NUMBER` words. A full polynomial of `DEPTH` rows is held in one of two ping-pong banks, then replayed row by row with the 4-bit row index that the bit-reverse stage consumes as its `cycle` input. One bank can fill while the other drains.

## Interface
Parameters:
- `DATA_SIZE`, default 32: coefficient width; matches `DATA_SIZE_ARB`.
- `PE_NUMBER`, default 32: coefficients per row.
- `DEPTH`, default 16: rows per polynomial. Fixed to 16 because `out_cycle` is 4 bits. Polynomial length N = `PE_NUMBER*DEPTH` = 512.

Ports:
- `clk`  in  1  the single clock.
- `reset`  in  1  asynchronous, active-high.
- `in_valid`  in  1  the coefficient on `in_data` is valid.
- `in_ready`  out  1  the loader can accept a coefficient this cycle.
- `in_data`  in  DATA_SIZE  coefficient; polynomial order, index 0 first.
- `in_last`  in  1  marks coefficient N-1; used only as a check.
- `out_valid`  out  1  `out_data` holds a valid row.
- `out_ready`  in  1  downstream accepts the row.
- `out_data`  out  PE_NUMBER*DATA_SIZE  row; word c is in bits [DATA_SIZE*c +: DATA_SIZE].
- `out_cycle`  out  4  row index r, 0..15.
- `out_first`  out  1  high with row 0.
- `out_last`  out  1  high with row 15.
- `err_len`  out  1  sticky flag for an `in_last` mismatch.

## Operation
- Handshake rule: a transfer occurs on an edge where valid && ready.
  - While `out_valid` is high and `out_ready` is low, `out_data`, `out_cycle`, `out_first` and `out_last` hold stable.
  - `out_valid` never drops without a transfer.
- Storage: two banks, each `DEPTH` x `PE_NUMBER` words.
- Bank state machine, per bank: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
  - EMPTY -> FILLING on the first accepted word.
  - FILLING -> FULL on accepted word N-1.
  - FULL -> DRAINING when the reader loads row 0.
  - DRAINING -> EMPTY on the row-15 output transfer.
- Writer:
  - Holds pointer `wr_bank` plus counters col (0..PE_NUMBER-1) and row (0..15).
  - An accepted word goes to `bank[wr_bank][row][col]`.
  - col wraps to 0 and increments row; after row 15 / col 31 it toggles `wr_bank` and clears the counters.
- `in_ready` = registered state of `bank[wr_bank]` is EMPTY or FILLING.
- Reader:
  - Holds pointer `rd_bank` and row counter `rd_row`.
  - The output register loads row `rd_row` of `rd_bank` when that bank is FULL or DRAINING and the output register is empty or transferring this edge.
  - `rd_row` wraps 15 -> 0 and toggles `rd_bank` after row 15 is loaded.
- Output fields: `out_cycle` = loaded row index; `out_first` = (row == 0); `out_last` = (row == 15).
- Length check:
  - `err_len` sets if an accepted word has `in_last` = 1 at an index other than N-1, or `in_last` = 0 at index N-1.
  - The bank still closes only after exactly N words; the counters are not resynchronised.
  - `err_len` clears only on reset.
- No combinational path from `out_ready` to `in_ready`, or from `in_valid` to `out_valid`.

## Timing
- Reset values:
  - Outputs: `in_ready` = 1, `out_valid` = 0, `out_data` = 0, `out_cycle` = 0, `out_first` = 0, `out_last` = 0, `err_len` = 0.
  - Internal: both banks EMPTY, `wr_bank` = `rd_bank` = 0, all counters 0. Bank contents are not reset.
- Latency:
  - Word N-1 accepted on edge E: the bank is FULL after E.
  - With the output register empty, row 0 appears with `out_valid` = 1 after edge E+1.
- Throughput:
  - 1 word/cycle in.
  - 1 row/cycle out while `out_ready` = 1, so 16 rows in 16 consecutive cycles.
- Bank reuse: if the row-15 transfer happens on edge T, that bank is EMPTY after T. If it is the `wr_bank`, `in_ready` rises in the cycle after T.
- Simultaneous events: a write closing bank A and the reader loading row 0 of bank B on the same edge are independent and both take effect.
- Full condition: both banks FULL or DRAINING -> `in_ready` = 0. `in_valid` is ignored while `in_ready` = 0.
- Reset mid-operation: an asynchronous assert immediately forces the reset values. Partial rows and partial polynomials are discarded, and `out_valid` falls without a transfer.

## Test plan
- Reset: assert `reset` mid-cycle -> all outputs reach their reset values without a clock edge; `in_ready` = 1 after release.
- Single polynomial: `in_data` = index 0..511, `in_last` on 511, `out_ready` = 1.
  - 16 rows; row r word c = 32r+c; `out_cycle` = r.
  - `out_first` only on r = 0, `out_last` only on r = 15.
  - First `out_valid` one edge after bank-full; `err_len` = 0.
- Back-pressure: toggle `out_ready` pseudo-randomly -> each row appears exactly once, in order, stable while stalled.
- Ping-pong: three polynomials back-to-back with `out_ready` = 0 -> `in_ready` drops after word 1024. Raising `out_ready` resumes input after row 15 of bank 0 transfers, and polynomial 3 lands in bank 0.
- Length error: `in_last` on index 100 -> `err_len` = 1 from that edge on; the bank still drains 16 rows after word 511 with data = index.
- Reset mid-drain: assert reset after row 7 -> `out_valid` = 0. A fresh polynomial then drains from row 0 with correct data.
